rst_sequencer: RTL and testbench

//  Consumes the already-synchronized, synchronously-applied reset and drives NUM_DOM downstream

---
 rtl/rst_seq_pkg.sv | 16 +
 rtl/rst_sequencer.sv | 140 ++++++++++++++
 tb/tb_rst_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer.
//   rst_seq_state_t : sequencer FSM states
//     HOLD - all domain resets asserted, counting the hold time
//     REL  - releasing domain resets in ascending order
//     RUN  - all domains released, accepting software reset requests
//     ASRT - re-asserting domain resets in descending order
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2,
    ASRT = 2'd3
  } rst_seq_state_t;

endpackage

// File: rtl/rst_sequencer.sv
// Ordered reset sequencer. Takes an already-synchronized reset and drives NUM_DOM
// downstream resets: released in ascending order after a hold period, re-asserted in
// descending order on a software/watchdog request accepted while running.
// Ports:
//   clk         : single clock
//   rst_sync_n  : synchronous active-low reset (priority over everything)
//   sw_rst_req  : level request for a full re-sequence, sampled only in RUN
//   sw_rst_ack  : one-cycle pulse when a request is accepted
//   dom_rst_n   : registered active-low per-domain resets
//   seq_done    : high while every domain is released (RUN)
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM     = 4,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned STAGGER_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_sync_n,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_done
);

  localparam int unsigned CntMax = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
  localparam int unsigned CNT_W  = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IDX_W  = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] StagLast = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(NUM_DOM - 1);

  rst_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    ack_d   = 1'b0;

    unique case (state_q)
      HOLD: begin
        if (cnt_q == HoldLast) begin
          state_d = REL;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      REL: begin
        // Release happens on the first cycle of each stagger slot.
        if (cnt_q == '0) begin
          for (int i = 0; i < int'(NUM_DOM); i++) begin
            if (idx_q == IDX_W'(i)) dom_d[i] = 1'b1;
          end
        end
        if (cnt_q == StagLast) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (sw_rst_req) begin
          ack_d   = 1'b1;
          done_d  = 1'b0;
          state_d = ASRT;
          idx_d   = IdxLast;
          cnt_d   = '0;
        end
      end

      ASRT: begin
        if (cnt_q == '0) begin
          for (int i = 0; i < int'(NUM_DOM); i++) begin
            if (idx_q == IDX_W'(i)) dom_d[i] = 1'b0;
          end
        end
        if (cnt_q == StagLast) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = HOLD;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        dom_d   = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign dom_rst_n  = dom_q;
  assign seq_done   = done_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default instance (N=4, H=16, S=8) and a minimal
// instance (N=1, H=1, S=1). Expected values come from closed-form timing formulas.
module tb_rst_sequencer;

  localparam int N = 4;
  localparam int H = 16;
  localparam int S = 8;
  localparam int SEQ = 2 * N * S + H;  // edges from accept until seq_done rises again

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         ack;
  logic [N-1:0] dom;
  logic         done;

  logic         rst6 = 1'b0;
  logic         req6 = 1'b0;
  logic         ack6;
  logic [0:0]   dom6;
  logic         done6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .NUM_DOM    (N),
    .HOLD_CYC   (H),
    .STAGGER_CYC(S)
  ) u_dut (
    .clk       (clk),
    .rst_sync_n(rst_n),
    .sw_rst_req(req),
    .sw_rst_ack(ack),
    .dom_rst_n (dom),
    .seq_done  (done)
  );

  rst_sequencer #(
    .NUM_DOM    (1),
    .HOLD_CYC   (1),
    .STAGGER_CYC(1)
  ) u_dut_min (
    .clk       (clk),
    .rst_sync_n(rst6),
    .sw_rst_req(req6),
    .sw_rst_ack(ack6),
    .dom_rst_n (dom6),
    .seq_done  (done6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected resets after edge k counted from the first edge with reset released.
  function automatic logic [N-1:0] exp_rel(input int k);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (k >= H + 1 + i * S);
    return r;
  endfunction

  // Expected resets after edge R+j, where R is the edge that accepted a request.
  function automatic logic [N-1:0] exp_sw(input int j);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = !(j >= 1 + (N - 1 - i) * S) || (j >= N * S + H + 1 + i * S);
    end
    return r;
  endfunction

  task automatic chk_all(input string tag, input int n, input logic [N-1:0] e_dom,
                         input logic e_ack, input logic e_done);
    chk($sformatf("%s_dom@%0d", tag, n), 32'(dom), 32'(e_dom));
    chk($sformatf("%s_ack@%0d", tag, n), 32'(ack), 32'(e_ack));
    chk($sformatf("%s_done@%0d", tag, n), 32'(done), 32'(e_done));
  endtask

  initial begin
    // 1. Reset held for 5 edges, then ordered release.
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("rst", k, '0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      chk_all("rel", k, exp_rel(k), 1'b0, k >= H + N * S);
    end
    tick();
    chk_all("run_idle", 49, '1, 1'b0, 1'b1);

    // 2/3. Single request, plus ignored pulses during ASRT (j=5) and REL (j=55).
    req = 1'b1;
    tick();
    req = 1'b0;
    chk_all("sw", 0, '1, 1'b1, 1'b0);
    for (int j = 1; j <= SEQ + 5; j++) begin
      req = (j == 5) || (j == 55);
      tick();
      chk_all("sw", j, exp_sw(j), 1'b0, j >= SEQ);
    end
    req = 1'b0;

    // 4. One-cycle reset mid-release after bit1 has risen.
    rst_n = 1'b0;
    tick();
    chk_all("rst2", 0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      chk_all("rel2", k, exp_rel(k), 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    tick();
    chk_all("midrst", 29, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      chk_all("rel3", k, exp_rel(k), 1'b0, k >= H + N * S);
    end

    // 5. Request held high: back-to-back sequences.
    req = 1'b1;
    for (int j = 0; j < 2 * (SEQ + 1); j++) begin
      tick();
      chk_all("held", j, exp_sw(j % (SEQ + 1)), (j % (SEQ + 1)) == 0,
              (j % (SEQ + 1)) == SEQ);
    end
    req = 1'b0;
    tick();
    chk_all("held_end", 0, '1, 1'b0, 1'b1);

    // Reset wins over a simultaneous request.
    req = 1'b1;
    rst_n = 1'b0;
    tick();
    chk_all("rst_prio", 0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req = 1'b0;

    // 6. Minimal configuration N=1, H=1, S=1.
    chk("min_rst_dom", 32'(dom6), 32'd0);
    rst6 = 1'b1;
    tick();
    chk("min_e1_dom", 32'(dom6), 32'd0);
    chk("min_e1_done", 32'(done6), 32'd0);
    tick();
    chk("min_e2_dom", 32'(dom6), 32'd1);
    chk("min_e2_done", 32'(done6), 32'd1);
    tick();
    chk("min_e3_done", 32'(done6), 32'd1);
    chk("min_e3_ack", 32'(ack6), 32'd0);
    req6 = 1'b1;
    tick();
    req6 = 1'b0;
    chk("min_r_ack", 32'(ack6), 32'd1);
    chk("min_r_done", 32'(done6), 32'd0);
    chk("min_r_dom", 32'(dom6), 32'd1);
    tick();
    chk("min_r1_dom", 32'(dom6), 32'd0);
    chk("min_r1_ack", 32'(ack6), 32'd0);
    tick();
    chk("min_r2_dom", 32'(dom6), 32'd0);
    chk("min_r2_done", 32'(done6), 32'd0);
    tick();
    chk("min_r3_dom", 32'(dom6), 32'd1);
    chk("min_r3_done", 32'(done6), 32'd1);
    tick();
    chk("min_r4_done", 32'(done6), 32'd1);
    chk("min_r4_ack", 32'(ack6), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
